// File: rtl/layer6_stream_ctrl.sv
// Layer-6 pass sequencer: producer stream -> SRAM port A, SRAM port B -> 2-entry skid -> consumer stream.
// Optional macro LAYER6_STALL_CNT_EN adds the stall_cnt consumer-backpressure counter output.
module layer6_stream_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [6:0]    fill_len,
  output logic          busy,
  output logic          done,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          sram_oea,
  output logic          sram_oeb,
  output logic          sram_wean,
  output logic          sram_webn,
  output logic [AW-1:0] sram_a,
  output logic [AW-1:0] sram_b,
  output logic [DW-1:0] sram_dia,
  output logic [DW-1:0] sram_dib,
  input  logic [DW-1:0] sram_dob
`ifdef LAYER6_STALL_CNT_EN
  , output logic [15:0] stall_cnt
`endif
);

  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg;
  logic          busy_reg, done_reg;
  logic [6:0]    len_reg, wr_cnt_reg, rd_ptr_reg, pop_cnt_reg;
  logic          inflight_reg;
  logic [1:0]    buf_cnt_reg;
  logic [DW-1:0] buf0_reg, buf1_reg, buf0_next, buf1_next;
  logic [AW-1:0] a_hold_reg, b_hold_reg;
  logic [DW-1:0] dia_hold_reg;

  logic          run, start_ok, wr_fire, pop, rd_issue;
  logic [2:0]    occ_after;
  logic [DW-1:0] head_src, second_src;

  assign run      = (state_reg == RUN);
  assign start_ok = (state_reg == IDLE) && start && (fill_len != 7'd0);
  assign busy     = busy_reg;
  assign done     = done_reg;

  assign wr_ready  = run && (wr_cnt_reg < len_reg);
  assign wr_fire   = wr_valid && wr_ready;
  assign sram_wean = ~wr_fire;
  assign sram_a    = wr_fire ? wr_cnt_reg[AW-1:0] : a_hold_reg;
  assign sram_dia  = wr_fire ? wr_data : dia_hold_reg;

  // The word in flight from port B counts as a FIFO entry and can be popped straight off sram_dob.
  assign rd_valid  = (buf_cnt_reg != 2'd0) || inflight_reg;
  assign rd_data   = (buf_cnt_reg != 2'd0) ? buf0_reg : sram_dob;
  assign pop       = rd_valid && rd_ready;
  assign occ_after = {1'b0, buf_cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign rd_issue  = run && (rd_ptr_reg < wr_cnt_reg) && (occ_after < 3'd2);
  assign sram_b    = rd_issue ? rd_ptr_reg[AW-1:0] : b_hold_reg;

  assign sram_oea  = 1'b0;
  assign sram_oeb  = run;
  assign sram_webn = 1'b1;
  assign sram_dib  = '0;

  always_comb begin
    head_src   = (buf_cnt_reg != 2'd0) ? buf0_reg : sram_dob;
    second_src = (buf_cnt_reg == 2'd2) ? buf1_reg : sram_dob;
    buf0_next  = pop ? second_src : head_src;
    buf1_next  = pop ? sram_dob : second_src;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      len_reg      <= '0;
      wr_cnt_reg   <= '0;
      rd_ptr_reg   <= '0;
      pop_cnt_reg  <= '0;
      inflight_reg <= 1'b0;
      buf_cnt_reg  <= '0;
      buf0_reg     <= '0;
      buf1_reg     <= '0;
      a_hold_reg   <= '0;
      b_hold_reg   <= '0;
      dia_hold_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            len_reg      <= (fill_len > DEPTH_C) ? DEPTH_C : fill_len;
            wr_cnt_reg   <= '0;
            rd_ptr_reg   <= '0;
            pop_cnt_reg  <= '0;
            inflight_reg <= 1'b0;
            buf_cnt_reg  <= '0;
            // Park port B on the top word so it cannot alias the first writes at address 0.
            b_hold_reg   <= '1;
            busy_reg     <= 1'b1;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          if (wr_fire) begin
            wr_cnt_reg   <= wr_cnt_reg + 7'd1;
            a_hold_reg   <= wr_cnt_reg[AW-1:0];
            dia_hold_reg <= wr_data;
          end
          if (rd_issue) begin
            rd_ptr_reg <= rd_ptr_reg + 7'd1;
            b_hold_reg <= rd_ptr_reg[AW-1:0];
          end
          inflight_reg <= rd_issue;
          buf_cnt_reg  <= occ_after[1:0];
          buf0_reg     <= buf0_next;
          buf1_reg     <= buf1_next;
          if (pop) begin
            pop_cnt_reg <= pop_cnt_reg + 7'd1;
            if ((pop_cnt_reg + 7'd1) == len_reg) begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef LAYER6_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (run && rd_valid && !rd_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_layer6_stream_ctrl.sv
// Directed bench for layer6_stream_ctrl with a behavioural dual-port SRAM model.
module tb_layer6_stream_ctrl;
  localparam int DW = 128;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [6:0]    fill_len = '0;
  logic          busy, done, wr_ready, rd_valid;
  logic          wr_valid = 1'b0;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          sram_oea, sram_oeb, sram_wean, sram_webn;
  logic [AW-1:0] sram_a, sram_b;
  logic [DW-1:0] sram_dia, sram_dib;
  logic [DW-1:0] sram_dob = '0;
`ifdef LAYER6_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  layer6_stream_ctrl #(.DEPTH(64), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .fill_len(fill_len),
    .busy(busy), .done(done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .sram_oea(sram_oea), .sram_oeb(sram_oeb), .sram_wean(sram_wean), .sram_webn(sram_webn),
    .sram_a(sram_a), .sram_b(sram_b), .sram_dia(sram_dia), .sram_dib(sram_dib),
    .sram_dob(sram_dob)
`ifdef LAYER6_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = {64'hBAD0_BAD0_BAD0_BAD0, 64'(i)};

  always @(posedge clk) begin
    if (!sram_wean) mem[sram_a] <= sram_dia;
    if (sram_oeb) sram_dob <= mem[sram_b];
  end

  int n_cmp = 0;
  int n_err = 0;

  // Port-collision watch: port B must never address the word port A is writing.
  always @(negedge clk) begin
    #2;
    if (!rst && !sram_wean) begin
      n_cmp++;
      if (sram_b === sram_a) begin
        n_err++;
        $display("FAIL port_collision: sram_b=%0d equals sram_a=%0d", sram_b, sram_a);
      end
    end
  end

  logic [DW-1:0] pop_data [0:127];
  int pop_cyc [0:127];
  int wr_cyc [0:127];
  int n_wr, n_pop, n_done, done_cyc, first_valid_cyc, busy_in_done, busy_after;
  bit timed_out;
  logic [15:0] stall_at_done;

  task automatic do_start(input logic [6:0] fl);
    @(negedge clk);
    start = 1'b1; fill_len = fl; wr_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives one pass and records what was observed; cycle 0 is the first cycle after the start edge.
  task automatic run_pass(input int period, input int rlo, input int rhi, input logic [63:0] tag,
                          input int stop_wr, input int max_cyc);
    bit seen_done;
    seen_done = 0;
    n_wr = 0; n_pop = 0; n_done = 0; done_cyc = -1; first_valid_cyc = -1;
    busy_in_done = -1; busy_after = -1; timed_out = 0; stall_at_done = '0;
    for (int k = 0; k < 128; k++) begin pop_data[k] = '0; pop_cyc[k] = -1; wr_cyc[k] = -1; end
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      wr_valid = (n_wr < 127) && (cyc % period == 0);
      wr_data  = {tag, 64'(n_wr)};
      rd_ready = !(cyc >= rlo && cyc <= rhi);
      #1;
      if (seen_done) begin
        busy_after = int'(busy);
        wr_valid = 1'b0; rd_ready = 1'b0;
        return;
      end
      if (rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (wr_valid && wr_ready) begin wr_cyc[n_wr] = cyc; n_wr++; end
      if (rd_valid && rd_ready && n_pop < 128) begin
        pop_data[n_pop] = rd_data; pop_cyc[n_pop] = cyc; n_pop++;
      end
      if (done) begin
        n_done++; done_cyc = cyc; busy_in_done = int'(busy); seen_done = 1;
`ifdef LAYER6_STALL_CNT_EN
        stall_at_done = stall_cnt;
`endif
      end
      if (stop_wr > 0 && n_wr >= stop_wr) return;
      @(negedge clk);
    end
    timed_out = 1;
    wr_valid = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++;
    if ({busy, done, wr_ready, rd_valid, sram_wean, sram_webn, sram_oea, sram_oeb} !== 8'b0000_1100) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 00001100",
               {busy, done, wr_ready, rd_valid, sram_wean, sram_webn, sram_oea, sram_oeb});
    end
    n_cmp++;
    if ({sram_a, sram_b} !== 12'd0 || sram_dia !== '0 || sram_dib !== '0) begin
      n_err++;
      $display("FAIL reset_bus: a=%0d b=%0d dia=%h dib=%h expected all 0", sram_a, sram_b, sram_dia, sram_dib);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_full_pass;
    do_start(7'd64);
    run_pass(1, -1, -2, 64'h0000_0000_0000_00A1, 0, 200);
    n_cmp++;
    if (timed_out || n_wr != 64 || n_pop != 64) begin
      n_err++;
      $display("FAIL full_counts: to=%0d wr=%0d pop=%0d expected 0/64/64", timed_out, n_wr, n_pop);
    end
    for (int k = 0; k < 64; k++) begin
      n_cmp++;
      if (pop_data[k] !== {64'h0000_0000_0000_00A1, 64'(k)}) begin
        n_err++;
        $display("FAIL full_data[%0d]: got %h expected low word %0d", k, pop_data[k], k);
      end
    end
    n_cmp++;
    if (wr_cyc[0] != 0 || first_valid_cyc != 2) begin
      n_err++;
      $display("FAIL full_latency: first write %0d first rd_valid %0d expected 0 and 2", wr_cyc[0], first_valid_cyc);
    end
    n_cmp++;
    if (pop_cyc[63] != 65 || done_cyc != 66 || n_done != 1) begin
      n_err++;
      $display("FAIL full_done: last pop %0d done %0d pulses %0d expected 65/66/1", pop_cyc[63], done_cyc, n_done);
    end
    n_cmp++;
    if (busy_in_done != 1 || busy_after != 0) begin
      n_err++;
      $display("FAIL full_busy: busy at done %0d after %0d expected 1 then 0", busy_in_done, busy_after);
    end
    $display("test_full_pass done: %0d words", n_pop);
  endtask

  task automatic test_backpressure;
    do_start(7'd8);
    run_pass(1, 3, 10, 64'h0000_0000_0000_00B2, 0, 100);
    n_cmp++;
    if (timed_out || n_wr != 8 || n_pop != 8 || n_done != 1) begin
      n_err++;
      $display("FAIL bp_counts: to=%0d wr=%0d pop=%0d done=%0d expected 0/8/8/1", timed_out, n_wr, n_pop, n_done);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (pop_data[k] !== {64'h0000_0000_0000_00B2, 64'(k)}) begin
        n_err++;
        $display("FAIL bp_data[%0d]: got %h expected low word %0d", k, pop_data[k], k);
      end
    end
    n_cmp++;
    if (pop_cyc[1] != 11 || done_cyc != 18) begin
      n_err++;
      $display("FAIL bp_timing: pop1 %0d done %0d expected 11 and 18", pop_cyc[1], done_cyc);
    end
    $display("test_backpressure done: %0d words", n_pop);
  endtask

  task automatic test_producer_gaps;
    do_start(7'd5);
    run_pass(3, -1, -2, 64'h0000_0000_0000_00C3, 0, 100);
    n_cmp++;
    if (timed_out || n_wr != 5 || n_pop != 5 || n_done != 1 || done_cyc != 15) begin
      n_err++;
      $display("FAIL gap_counts: to=%0d wr=%0d pop=%0d done=%0d@%0d expected 0/5/5/1@15",
               timed_out, n_wr, n_pop, n_done, done_cyc);
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (pop_data[k] !== {64'h0000_0000_0000_00C3, 64'(k)} || wr_cyc[k] != 3 * k || pop_cyc[k] != 3 * k + 2) begin
        n_err++;
        $display("FAIL gap_word[%0d]: data %h wr@%0d pop@%0d expected low %0d wr@%0d pop@%0d",
                 k, pop_data[k], wr_cyc[k], pop_cyc[k], k, 3 * k, 3 * k + 2);
      end
    end
    $display("test_producer_gaps done: %0d words", n_pop);
  endtask

  task automatic test_boundary;
    do_start(7'd0);
    wr_valid = 1'b1; rd_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (busy !== 1'b0 || wr_ready !== 1'b0 || sram_oeb !== 1'b0) begin
        n_err++;
        $display("FAIL len0_ignored: busy=%b wr_ready=%b oeb=%b expected 0/0/0", busy, wr_ready, sram_oeb);
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    do_start(7'd100);
    run_pass(1, -1, -2, 64'h0000_0000_0000_00D4, 0, 200);
    n_cmp++;
    if (timed_out || n_wr != 64 || n_pop != 64 || done_cyc != 66) begin
      n_err++;
      $display("FAIL len100_clamp: to=%0d wr=%0d pop=%0d done@%0d expected 0/64/64/66",
               timed_out, n_wr, n_pop, done_cyc);
    end
    n_cmp++;
    if (pop_data[63] !== {64'h0000_0000_0000_00D4, 64'd63}) begin
      n_err++;
      $display("FAIL len100_last: got %h expected low word 63", pop_data[63]);
    end
    $display("test_boundary done");
  endtask

  task automatic test_async_reset;
    do_start(7'd64);
    run_pass(1, -1, -2, 64'h0000_0000_0000_00E5, 20, 200);
    n_cmp++;
    if (sram_wean !== 1'b0 || sram_a !== 6'd19 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pre: wean=%b a=%0d busy=%b expected 0/19/1", sram_wean, sram_a, busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, wr_ready, rd_valid, sram_wean, sram_webn, sram_oea, sram_oeb} !== 8'b0000_1100) begin
      n_err++;
      $display("FAIL arst_ctrl: got %b expected 00001100",
               {busy, done, wr_ready, rd_valid, sram_wean, sram_webn, sram_oea, sram_oeb});
    end
    n_cmp++;
    if ({sram_a, sram_b} !== 12'd0 || sram_dia !== '0 || sram_dib !== '0) begin
      n_err++;
      $display("FAIL arst_bus: a=%0d b=%0d dia=%h dib=%h expected all 0", sram_a, sram_b, sram_dia, sram_dib);
    end
    @(negedge clk);
    wr_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_start(7'd4);
    run_pass(1, -1, -2, 64'h0000_0000_0000_00F6, 0, 100);
    n_cmp++;
    if (timed_out || n_pop != 4 || n_done != 1) begin
      n_err++;
      $display("FAIL arst_rerun: to=%0d pop=%0d done=%0d expected 0/4/1", timed_out, n_pop, n_done);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (pop_data[k] !== {64'h0000_0000_0000_00F6, 64'(k)}) begin
        n_err++;
        $display("FAIL arst_data[%0d]: got %h expected low word %0d", k, pop_data[k], k);
      end
    end
    $display("test_async_reset done");
  endtask

`ifdef LAYER6_STALL_CNT_EN
  task automatic test_stall;
    do_start(7'd4);
    run_pass(1, 2, 7, 64'h0000_0000_0000_0017, 0, 100);
    n_cmp++;
    if (timed_out || n_pop != 4 || stall_at_done !== 16'd6) begin
      n_err++;
      $display("FAIL stall_cnt: to=%0d pop=%0d stall=%0d expected 0/4/6", timed_out, n_pop, stall_at_done);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (pop_data[k] !== {64'h0000_0000_0000_0017, 64'(k)}) begin
        n_err++;
        $display("FAIL stall_data[%0d]: got %h expected low word %0d", k, pop_data[k], k);
      end
    end
    $display("test_stall done: stall_cnt=%0d", stall_at_done);
  endtask
`endif

  initial begin
    test_reset;
    test_full_pass;
    test_backpressure;
    test_producer_gaps;
    test_boundary;
    test_async_reset;
`ifdef LAYER6_STALL_CNT_EN
    test_stall;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
